alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter that shares the single combinational ALU datapath (`ALU`: add/sub, sll, xor, or, and) between NREQ requesters, such as issue slots or a debug port. It accepts one request per cycle through valid/ready handshakes and evaluates it on the shared ALU. The result is captured in a one-entry output register and returned through one response channel tagged with the requester index. It sits between the issue logic and writeback.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NREQ)`: requester index width.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NREQ: per-requester request valid.
- `req_ready`, output, NREQ: per-requester accept; at most one bit high (one-hot or zero).
- `req_a`, input, NREQ×32: operand A per requester.
- `req_b`, input, NREQ×32: operand B per requester.
- `req_funct3`, input, NREQ×3: ALU funct3 per requester.
- `req_funct7`, input, NREQ×7: ALU funct7 per requester.
- `rsp_valid`, output, 1: response register full.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_data`, output, 32: ALU result.
- `rsp_id`, output, ID_W: index of the requester that produced `rsp_data`.
- `rsp_err`, output, 1: funct3 was unsupported (2, 3 or 5).

## Operation
- **Slot free:** `free = !rsp_valid || rsp_ready`.
- **Grant:** when `free` is high and any `req_valid` is high, grant the first valid requester at or after `ptr`, searching cyclically (ptr, ptr+1, …, NREQ-1, 0, …).
  - `req_ready[g]` is high only for that winner.
  - `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`.
- **Pointer update:**
  - On a handshake with requester g: `ptr <= (g+1) mod NREQ`.
  - With no handshake, `ptr` holds.
  - `ptr` resets to 0.
- **Datapath:** the winner's a/b/funct3/funct7 are muxed into one ALU instance. On the handshake edge:
  - `rsp_data <=` ALU output.
  - `rsp_id <= g`.
  - `rsp_err <= (funct3 ∈ {2,3,5})`.
  - `rsp_valid <= 1`.
- **ALU behaviour passed through unchanged:**
  - funct3=0: funct7=0 gives A+B; any other funct7 gives A−B.
  - funct3=1: shift left by B[4:0].
  - funct3=4/6/7: xor, or, and.
  - Unsupported funct3: data 32'h0000cccc with `rsp_err`=1.
  - Arithmetic is mod 2^32, with no overflow flag.
- **Response hold:** with `rsp_valid`=1 and `rsp_ready`=0, all rsp_* outputs hold stable and every `req_ready` is 0.
- **Simultaneous drain and accept:** if `rsp_ready`=1 while full and a request is granted in the same cycle, the register is overwritten with the new result and `rsp_valid` stays 1. This gives full throughput of 1 per cycle.
- **Drain only:** `rsp_ready`=1 with no request clears `rsp_valid` at the next edge. `rsp_data`/`rsp_id`/`rsp_err` hold their last values, so they are don't-care.
- **Requester rules:**
  - A requester holds `req_valid` and its payload stable until it sees `req_ready`.
  - Deasserting `req_valid` before the grant is tolerated, but it is not a protocol requirement on the block.

## Timing
- **Reset:**
  - While `rst`=1, `req_ready` is forced to 0.
  - At the next edge: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0, `ptr`=0.
  - Reset while a response is pending discards it.
- **Latency:** a request accepted at edge N has its response visible after edge N, i.e. 1 cycle.
- **Fairness:** with all NREQ requesters continuously valid and `rsp_ready`=1, grants rotate 0,1,…,NREQ-1,0. Each requester waits at most NREQ-1 cycles beyond backpressure.
- **Idle cycles:** with no requests valid, `ptr` does not advance.

## Structure
- **Package `alu_pkg`:**
  - funct3 constants: F3_ADDSUB=3'h0, F3_SLL=3'h1, F3_XOR=3'h4, F3_OR=3'h6, F3_AND=3'h7.
  - F7_SUB=7'h20.
  - Packed struct `alu_req_t` holding a, b, funct3 and funct7.
  - Function `f3_supported()`.
- **Sub-module `rr_picker`:** (NREQ, valid vector, ptr) → one-hot grant plus encoded index. It is purely combinational and reusable by other arbiters.
- **Shared ALU:** exactly one `ALU` instance.

## Test plan
- **Reset:** reset mid-flight with `rsp_valid`=1 → after one cycle `rsp_valid`=0, `ptr`=0, `req_ready`=0 throughout reset.
- **Single request:** req1 only, a=5, b=3, f3=0, f7=0 → `req_ready`=4'b0010; next cycle `rsp_data`=8, `rsp_id`=1, `rsp_err`=0.
- **Round robin under load:** all four valid for 8 cycles with `rsp_ready`=1 → grant order 0,1,2,3,0,1,2,3; each response matches its requester's op. Subtract case: a=3, b=5, f7=7'h20 → 32'hFFFFFFFE.
- **Backpressure:**
  - Hold `rsp_ready`=0 for 3 cycles with req2 valid → `req_ready` stays 0 and rsp outputs stay stable.
  - Release → the drain and req2's accept occur in the same cycle.
  - `rsp_valid` stays 1 with the new data.
- **Ops and error:**
  - f3=1, a=1, b=32'h23 → data 8.
  - f3=6, a=32'hF0, b=32'h0F → data 32'hFF.
  - f3=5 → data 32'h0000cccc, `rsp_err`=1.
- **Pointer skip:**
  - `ptr`=3 with only req1 valid → grant 1, then `ptr`=2.
  - Idle cycles leave `ptr` unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings, request bundle and helpers for the ALU arbiter.
package alu_pkg;

    localparam logic [2:0] F3_ADDSUB = 3'h0;
    localparam logic [2:0] F3_SLL    = 3'h1;
    localparam logic [2:0] F3_XOR    = 3'h4;
    localparam logic [2:0] F3_OR     = 3'h6;
    localparam logic [2:0] F3_AND    = 3'h7;

    localparam logic [6:0] F7_SUB    = 7'h20;

    // Result pattern returned for funct3 encodings the ALU does not implement.
    localparam logic [31:0] ALU_BAD_DATA = 32'h0000cccc;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } alu_req_t;

    function automatic logic f3_supported(input logic [2:0] f3);
        return (f3 == F3_ADDSUB) || (f3 == F3_SLL) || (f3 == F3_XOR) ||
               (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU: add/sub, sll, xor, or, and. Mod 2^32, no flags.
module ALU
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] y
);

    // Decode funct3; any non-zero funct7 on ADDSUB selects subtract.
    always_comb begin
        y = ALU_BAD_DATA;
        case (funct3)
            F3_ADDSUB: y = (funct7 == 7'h00) ? (a + b) : (a - b);
            F3_SLL:    y = a << b[4:0];
            F3_XOR:    y = a ^ b;
            F3_OR:     y = a | b;
            F3_AND:    y = a & b;
            default:   y = ALU_BAD_DATA;
        endcase
    end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index at or after ptr, cyclic.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    // Two passes: indices >= ptr first, then wrap to the low indices.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!any && valid[j] && (j >= int'(ptr))) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!any && valid[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, one-entry
// response register, one result per cycle when the consumer keeps up.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    input  logic [NREQ-1:0][2:0]  req_funct3,
    input  logic [NREQ-1:0][6:0]  req_funct7,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            rsp_err_q, rsp_err_d;

    logic            free;
    logic            take;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gidx;
    logic            gany;
    alu_req_t        win;
    logic [31:0]     alu_y;

    // Slot can take a new result if empty or being drained this cycle.
    assign free = !rsp_valid_q || rsp_ready;
    assign take = !rst && free && gany;

    rr_picker #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .gnt   (gnt),
        .idx   (gidx),
        .any   (gany)
    );

    // Accept only the picked requester, and never while in reset.
    always_comb begin
        req_ready = '0;
        if (!rst && free) begin
            req_ready = gnt;
        end
    end

    // Steer the winner's operands into the single ALU.
    always_comb begin
        win.a      = req_a[gidx];
        win.b      = req_b[gidx];
        win.funct3 = req_funct3[gidx];
        win.funct7 = req_funct7[gidx];
    end

    ALU u_alu (
        .a      (win.a),
        .b      (win.b),
        .funct3 (win.funct3),
        .funct7 (win.funct7),
        .y      (alu_y)
    );

    // Capture on handshake (overwriting a drained entry), clear on drain only.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        if (take) begin
            ptr_d       = (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + ID_W'(1);
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_y;
            rsp_id_d    = gidx;
            rsp_err_d   = !f3_supported(win.funct3);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

endmodule
